// File: rtl/classic_clock_pkg.sv
// ---------------------------------------------------------------------------
// classic_clock_pkg
//
// Shared definitions for the classic clock front end: button channel
// indices, default timing for a 25.175 MHz pixel clock, the auto-repeat
// state encoding and a small constant helper.
//
// No ports (package).
// ---------------------------------------------------------------------------
package classic_clock_pkg;

    // Button channel layout as seen by classic_vga_clock
    localparam int N_BTN         = 5;
    localparam int BTN_HOUR      = 0;
    localparam int BTN_MIN       = 1;
    localparam int BTN_SEC       = 2;
    localparam int BTN_AL        = 3;
    localparam int BTN_AL_TOGGLE = 4;

    // Default timing at 25.175 MHz: ~5 ms debounce, ~0.5 s first repeat,
    // ~0.1 s between subsequent repeats
    localparam int DEBOUNCE_CYCLES_DEFAULT = 125000;
    localparam int REPEAT_DELAY_DEFAULT    = 12500000;
    localparam int REPEAT_PERIOD_DEFAULT   = 2500000;

    // Hour, minute and second repeat; alarm-set and alarm toggle do not
    localparam logic [N_BTN-1:0] REPEAT_MASK_DEFAULT = 5'b00111;

    // Auto-repeat state per channel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
//
// One push-button path: two-flop synchronizer, debounce counter and an
// optional auto-repeat FSM that re-issues the press pulse while held.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high reset
//   btn_in    - raw asynchronous button pin (active-high)
//   btn_level - debounced, synchronized button state
//   btn_pulse - one-cycle pulse on press and on each auto-repeat
// ---------------------------------------------------------------------------
module button_channel
    import classic_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;
    logic             rise_evt;
    logic             fall_evt;
    logic             rep_fire;

    // Plain two-flop synchronizer; nothing may sit between the flops so the
    // first stage has a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
        end
    end

    // A new level is accepted on the edge where the disagreeing sample has
    // been seen DEBOUNCE_CYCLES times in a row; these events drive both the
    // press pulse and the repeat FSM on that same edge.
    assign deb_done = (sync != btn_level) && (deb_cnt == DEB_LAST);
    assign rise_evt = deb_done & sync;
    assign fall_evt = deb_done & ~sync;

    // Debounce: any agreement with the current level restarts the count,
    // so bounces shorter than the window never reach the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else if (sync == btn_level) begin
            deb_cnt <= '0;
        end else if (deb_done) begin
            btn_level <= sync;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int REP_W =
                $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
            localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
            localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

            rep_state_t       rep_state;
            logic [REP_W-1:0] rep_cnt;

            assign rep_fire = ((rep_state == DELAY)  && (rep_cnt == DELAY_LAST)) ||
                              ((rep_state == REPEAT) && (rep_cnt == PERIOD_LAST));

            // Repeat timer starts on the press edge itself, so the first
            // repeat lands REPEAT_DELAY cycles after the press pulse. An
            // accepted release overrides everything and parks the FSM.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rep_state <= IDLE;
                    rep_cnt   <= '0;
                end else if (fall_evt) begin
                    rep_state <= IDLE;
                    rep_cnt   <= '0;
                end else begin
                    case (rep_state)
                        IDLE: begin
                            if (rise_evt) begin
                                rep_state <= DELAY;
                                rep_cnt   <= '0;
                            end
                        end
                        DELAY: begin
                            if (rep_cnt == DELAY_LAST) begin
                                rep_state <= REPEAT;
                                rep_cnt   <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (rep_cnt == PERIOD_LAST) begin
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end
                        default: begin
                            rep_state <= IDLE;
                            rep_cnt   <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_no_repeat
            assign rep_fire = 1'b0;
        end
    endgenerate

    // Registered pulse, aligned with the level update. A release landing on
    // a repeat slot suppresses that repeat so a pulse never outlives the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= rise_evt | (rep_fire & ~fall_evt);
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Front end for classic_vga_clock: turns the raw hour/min/sec/alarm-set/
// alarm-toggle pins into debounced levels and press/auto-repeat pulses.
// Channels are fully independent.
//
// Ports:
//   clk       - system clock (pixel clock domain)
//   reset     - asynchronous, active-high reset
//   btn_in    - raw asynchronous button pins [N_BTN-1:0]
//   btn_level - debounced, synchronized button state [N_BTN-1:0]
//   btn_pulse - one-cycle pulse per press and per auto-repeat [N_BTN-1:0]
// ---------------------------------------------------------------------------
module button_conditioner
    import classic_clock_pkg::*;
#(
    parameter int               N_BTN           = classic_clock_pkg::N_BTN,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    // One self-contained channel per button; the mask bit decides whether
    // that channel builds its repeat FSM at all.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .btn_in   (btn_in[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Scoreboard bench for button_conditioner with short timing
// (debounce 4, repeat delay 10, repeat period 3). Stimulus pushes the
// expected pulse cycles; an independent monitor pops them whenever any
// pulse appears.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
    import classic_clock_pkg::*;

    localparam int DEB = 4;
    localparam int RDL = 10;
    localparam int RPR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_in = 5'b0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDL),
        .REPEAT_PERIOD  (RPR),
        .REPEAT_MASK    (5'b00111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    // Clock and free-running edge counter; cyc = index of the last rising edge
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every nonzero pulse vector must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (btn_pulse !== 5'b0) begin
            checks++;
            if ((btn_pulse & ~btn_level) !== 5'b0) begin
                failures++;
                $display("[TB] FAIL pulse_without_level: cyc=%0d pulse=%b level=%b required no pulse on low level",
                         cyc, btn_pulse, btn_level);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: cyc=%0d actual=%b required=none", cyc, btn_pulse);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== btn_pulse) begin
                    failures++;
                    $display("[TB] FAIL pulse_match: actual cyc=%0d vec=%b required cyc=%0d vec=%b",
                             cyc, btn_pulse, e.cyc, e.vec);
                end
            end
        end
    end

    task automatic atNegedge(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic applyStimulus(input logic [4:0] v);
        btn_in = v;
    endtask

    task automatic expectPulse(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp_level);
        checks++;
        if (btn_level !== exp_level) begin
            failures++;
            $display("[TB] FAIL %s: cyc=%0d btn_level actual=%b required=%b", name, cyc, btn_level, exp_level);
        end
    endtask

    task automatic checkPulseZero(input string name);
        checks++;
        if (btn_pulse !== 5'b0) begin
            failures++;
            $display("[TB] FAIL %s: btn_pulse actual=%b required=00000", name, btn_pulse);
        end
    endtask

    task automatic drainCheck(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: missing pulses actual_pending=%0d required=0 next_cyc=%0d",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        int t0;
        int t1;

        // Reset state
        #1;
        checkOutput("reset_level", 5'b0);
        checkPulseZero("reset_pulse");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        atNegedge(cyc + 2);

        // Clean press on hour with auto-repeat: pulses at 6, 16, 19, 22
        @(negedge clk);
        t0 = cyc;
        applyStimulus(5'b00001);
        expectPulse(t0 + 6, 5'b00001);
        expectPulse(t0 + 16, 5'b00001);
        expectPulse(t0 + 19, 5'b00001);
        expectPulse(t0 + 22, 5'b00001);
        atNegedge(t0 + 5);
        checkOutput("press_level_early", 5'b00000);
        atNegedge(t0 + 6);
        checkOutput("press_level", 5'b00001);
        atNegedge(t0 + 17);
        applyStimulus(5'b00000);
        atNegedge(t0 + 22);
        checkOutput("held_level", 5'b00001);
        atNegedge(t0 + 23);
        checkOutput("release_level", 5'b00000);
        atNegedge(t0 + 30);
        drainCheck("clean_press_repeat");

        // Masked alarm-toggle channel: single press pulse, no repeats
        t0 = cyc;
        applyStimulus(5'b10000);
        expectPulse(t0 + 6, 5'b10000);
        atNegedge(t0 + 6);
        checkOutput("masked_level", 5'b10000);
        atNegedge(t0 + 30);
        checkOutput("masked_held", 5'b10000);
        applyStimulus(5'b00000);
        atNegedge(t0 + 36);
        checkOutput("masked_release", 5'b00000);
        atNegedge(t0 + 40);
        drainCheck("masked_channel");

        // Bounce on minute: high 3, low 1, high 2, low -> nothing accepted
        t0 = cyc;
        applyStimulus(5'b00010);
        atNegedge(t0 + 3);
        applyStimulus(5'b00000);
        atNegedge(t0 + 4);
        applyStimulus(5'b00010);
        atNegedge(t0 + 6);
        applyStimulus(5'b00000);
        for (int k = 7; k <= 14; k++) begin
            atNegedge(t0 + k);
            checkOutput("bounce_level", 5'b00000);
        end
        drainCheck("bounce");

        // Second channel released so the level falls exactly on the first
        // repeat slot (16): release wins, then a re-press pulses afresh
        t0 = cyc;
        applyStimulus(5'b00100);
        expectPulse(t0 + 6, 5'b00100);
        atNegedge(t0 + 10);
        applyStimulus(5'b00000);
        atNegedge(t0 + 15);
        checkOutput("slot_level_before", 5'b00100);
        atNegedge(t0 + 16);
        checkOutput("slot_level_fall", 5'b00000);
        atNegedge(t0 + 24);
        t1 = cyc;
        applyStimulus(5'b00100);
        expectPulse(t1 + 6, 5'b00100);
        atNegedge(t1 + 6);
        checkOutput("repress_level", 5'b00100);
        atNegedge(t1 + 8);
        applyStimulus(5'b00000);
        atNegedge(t1 + 20);
        checkOutput("repress_release", 5'b00000);
        drainCheck("release_at_slot");

        // Async reset mid-hold at cycle 18, released during cycle 19
        t0 = cyc;
        applyStimulus(5'b00001);
        expectPulse(t0 + 6, 5'b00001);
        expectPulse(t0 + 16, 5'b00001);
        expectPulse(t0 + 25, 5'b00001);
        atNegedge(t0 + 17);
        checkOutput("pre_reset_level", 5'b00001);
        atNegedge(t0 + 18);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_level", 5'b00000);
        checkPulseZero("async_reset_pulse");
        atNegedge(t0 + 19);
        reset = 1'b0;
        atNegedge(t0 + 24);
        checkOutput("post_reset_early", 5'b00000);
        atNegedge(t0 + 25);
        checkOutput("post_reset_level", 5'b00001);
        atNegedge(t0 + 27);
        applyStimulus(5'b00000);
        atNegedge(t0 + 33);
        checkOutput("post_reset_release", 5'b00000);
        atNegedge(t0 + 40);
        drainCheck("reset_mid_hold");

        // All five channels together: shared press, then repeats on 0..2
        t0 = cyc;
        applyStimulus(5'b11111);
        expectPulse(t0 + 6, 5'b11111);
        expectPulse(t0 + 16, 5'b00111);
        expectPulse(t0 + 19, 5'b00111);
        expectPulse(t0 + 22, 5'b00111);
        atNegedge(t0 + 6);
        checkOutput("all_level", 5'b11111);
        atNegedge(t0 + 17);
        applyStimulus(5'b00000);
        atNegedge(t0 + 23);
        checkOutput("all_release", 5'b00000);
        atNegedge(t0 + 30);
        drainCheck("all_channels");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
